uart_rx_ctrl: RTL

AXI4-Lite read master that drains received bytes from the UART Lite core's RX FIFO. It is the receive-side counterpart of the TX write controller, on the same UART Lite slave port.
- Polls the status register (0x8) at a fixed interval.
- When RX-valid is set, reads the RX FIFO register (0x0).
- Presents each byte on a valid/ready stream to downstream logic.
- Reports UART line errors and AXI read errors as one-cycle pulses.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART Lite definitions used by the RX and TX AXI4-Lite controllers.
package uart_pkg;

  // UART Lite register offsets on the AXI4-Lite slave port
  localparam logic [3:0] UART_RX_FIFO = 4'h0;
  localparam logic [3:0] UART_TX_FIFO = 4'h4;
  localparam logic [3:0] UART_STAT    = 4'h8;
  localparam logic [3:0] UART_CTRL    = 4'hC;

  // Status register bit positions
  localparam int unsigned STAT_RX_VALID = 0;
  localparam int unsigned STAT_OVERRUN  = 5;
  localparam int unsigned STAT_FRAME    = 6;
  localparam int unsigned STAT_PARITY   = 7;

  // AXI read/write response codes
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Receive controller states
  typedef enum logic [2:0] {
    POLL_AR = 3'd0,
    POLL_R  = 3'd1,
    GAP     = 3'd2,
    FIFO_AR = 3'd3,
    FIFO_R  = 3'd4,
    HOLD    = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl.sv
// AXI4-Lite read master that polls the UART Lite status register, drains the
// RX FIFO one byte at a time and hands each byte to a valid/ready consumer.
// Line errors and AXI read errors are reported as single-cycle pulses.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int POLL_GAP = 16,
  parameter int GAP_W    = $clog2(POLL_GAP + 1)
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] araddr,
  output logic       arvalid,
  input  logic       arready,
  input  logic [7:0] rdata,
  input  logic [1:0] rresp,
  input  logic       rvalid,
  output logic       rready,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic [2:0] line_err,
  output logic       rresp_err
);

  // Last value of the gap counter before the next poll is issued
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  rx_state_e        state_q, state_d;
  logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic [2:0]       lineErr_q, lineErr_d;
  logic             rrespErr_q, rrespErr_d;

  // State, gap counter, output byte and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= POLL_AR;
      gapCnt_q   <= '0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      lineErr_q  <= 3'b000;
      rrespErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gapCnt_q   <= gapCnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      lineErr_q  <= lineErr_d;
      rrespErr_q <= rrespErr_d;
    end
  end

  // Next-state logic; error pulses default low so they last exactly one cycle
  always_comb begin
    state_d    = state_q;
    gapCnt_d   = gapCnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    lineErr_d  = 3'b000;
    rrespErr_d = 1'b0;

    case (state_q)
      POLL_AR: begin
        if (arready) begin
          state_d = POLL_R;
        end
      end

      POLL_R: begin
        if (rvalid) begin
          if (rresp != RESP_OKAY) begin
            rrespErr_d = 1'b1;
            gapCnt_d   = '0;
            state_d    = GAP;
          end else begin
            lineErr_d = rdata[STAT_PARITY:STAT_OVERRUN];
            if (rdata[STAT_RX_VALID]) begin
              state_d = FIFO_AR;
            end else begin
              gapCnt_d = '0;
              state_d  = GAP;
            end
          end
        end
      end

      GAP: begin
        if (gapCnt_q == GAP_LAST) begin
          state_d = POLL_AR;
        end else begin
          gapCnt_d = gapCnt_q + GAP_W'(1);
        end
      end

      FIFO_AR: begin
        if (arready) begin
          state_d = FIFO_R;
        end
      end

      FIFO_R: begin
        if (rvalid) begin
          if (rresp == RESP_OKAY) begin
            data_d  = rdata;
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            rrespErr_d = 1'b1;
            state_d    = POLL_AR;
          end
        end
      end

      HOLD: begin
        if (ready) begin
          valid_d = 1'b0;
          state_d = POLL_AR;
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = POLL_AR;
      end
    endcase
  end

  // AXI read channel outputs decoded purely from the registered state
  always_comb begin
    araddr  = 4'h0;
    arvalid = 1'b0;
    rready  = 1'b0;
    case (state_q)
      POLL_AR: begin
        araddr  = UART_STAT;
        arvalid = 1'b1;
      end
      FIFO_AR: begin
        araddr  = UART_RX_FIFO;
        arvalid = 1'b1;
      end
      POLL_R,
      FIFO_R: begin
        rready = 1'b1;
      end
      default: begin
        araddr  = 4'h0;
        arvalid = 1'b0;
        rready  = 1'b0;
      end
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign line_err  = lineErr_q;
  assign rresp_err = rrespErr_q;

endmodule
